// File: rtl/at_cmd_sequencer.sv
// at_cmd_sequencer: streams AT commands from a table to UART TX and checks each "OK"/"ERROR" reply
module at_cmd_sequencer #(
  parameter int CMD_WIDTH       = 32,
  parameter int MAX_CMDS        = 16,
  parameter int ADDR_W          = 10,
  parameter int MAX_RETRIES     = 2,
  parameter int ACK_TIMEOUT_CYC = 210000,
  parameter int FLUSH_QUIET_CYC = 2000,
  parameter int TMR_W           = 24
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_i,
  input  logic                          abort_i,
  output logic                          mem_rd_en_o,
  output logic [ADDR_W-1:0]             mem_addr_o,
  input  logic [7:0]                    mem_rd_data_i,
  input  logic                          mem_rd_valid_i,
  output logic                          tx_valid_o,
  output logic [7:0]                    tx_data_o,
  input  logic                          tx_ready_i,
  input  logic                          rx_valid_i,
  input  logic [7:0]                    rx_data_i,
  output logic                          rx_rd_en_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          fail_o,
  output logic [2:0]                    fail_code_o,
  output logic [$clog2(MAX_CMDS+1)-1:0] fail_cmd_o,
  output logic [$clog2(MAX_CMDS+1)-1:0] cmds_ok_o
);
  localparam int KW = $clog2(MAX_CMDS+1);
  localparam int IW = $clog2(CMD_WIDTH+1);
  localparam int RW = $clog2(MAX_RETRIES+2);
  typedef enum logic [3:0] {
    S_IDLE, S_LOAD_N, S_FETCH, S_LATCH, S_SEND, S_WAIT, S_FLUSH, S_DONE, S_FAIL
  } state_t;
  state_t            state_q;
  logic              mem_rd_en_q, tx_valid_q, busy_q, done_q, fail_q, cr_q;
  logic [ADDR_W-1:0] mem_addr_q, base_q;
  logic [7:0]        tx_data_q;
  logic [2:0]        fail_code_q;
  logic [KW-1:0]     fail_cmd_q, k_q, n_q;
  logic [IW-1:0]     idx_q;
  logic [RW-1:0]     r_q;
  logic [TMR_W-1:0]  tmr_q;
  logic [39:0]       win_q;
  logic              win_ok_d, win_err_d, last_d, bad_n_d;
  assign win_ok_d    = win_q[15:0] == 16'h4F4B;
  assign win_err_d   = win_q == 40'h4552524F52;
  assign last_d      = cr_q && tx_data_q == 8'h0A;
  assign bad_n_d     = mem_rd_data_i[4:0] == 5'd0 || int'(mem_rd_data_i[4:0]) > MAX_CMDS;
  assign rx_rd_en_o  = rx_valid_i && (state_q == S_WAIT || state_q == S_FLUSH);
  assign mem_rd_en_o = mem_rd_en_q;
  assign mem_addr_o  = mem_addr_q;
  assign tx_valid_o  = tx_valid_q;
  assign tx_data_o   = tx_data_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign fail_o      = fail_q;
  assign fail_code_o = fail_code_q;
  assign fail_cmd_o  = fail_cmd_q;
  assign cmds_ok_o   = k_q;
  // Sequencer FSM: table fetch, byte-wise TX handshake, reply matching, retry and RX flush
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mem_rd_en_q <= 1'b0;
      mem_addr_q  <= '0;
      base_q      <= '0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_code_q <= '0;
      fail_cmd_q  <= '0;
      k_q         <= '0;
      n_q         <= '0;
      idx_q       <= '0;
      r_q         <= '0;
      cr_q        <= 1'b0;
      tmr_q       <= '0;
      win_q       <= '0;
    end else begin
      mem_rd_en_q <= 1'b0;
      if (abort_i && state_q != S_IDLE) begin
        state_q     <= S_IDLE;
        tx_valid_q  <= 1'b0;
        busy_q      <= 1'b0;
        done_q      <= 1'b0;
        fail_q      <= 1'b1;
        fail_code_q <= 3'd5;
        fail_cmd_q  <= k_q;
      end else begin
        case (state_q)
          S_IDLE: if (start_i) begin
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_code_q <= '0;
            fail_cmd_q  <= '0;
            k_q         <= '0;
            mem_rd_en_q <= 1'b1;
            mem_addr_q  <= '0;
            state_q     <= S_LOAD_N;
          end
          S_LOAD_N: if (mem_rd_valid_i) begin
            n_q         <= KW'(mem_rd_data_i[4:0]);
            r_q         <= '0;
            idx_q       <= '0;
            cr_q        <= 1'b0;
            base_q      <= ADDR_W'(1);
            state_q     <= bad_n_d ? S_FAIL : S_FETCH;
            fail_q      <= bad_n_d;
            busy_q      <= !bad_n_d;
            fail_code_q <= bad_n_d ? 3'd1 : 3'd0;
          end
          S_FETCH: begin
            mem_rd_en_q <= 1'b1;
            mem_addr_q  <= base_q + ADDR_W'(idx_q);
            state_q     <= S_LATCH;
          end
          S_LATCH: if (mem_rd_valid_i) begin
            tx_data_q  <= mem_rd_data_i;
            tx_valid_q <= 1'b1;
            state_q    <= S_SEND;
          end
          S_SEND: if (tx_ready_i) begin
            tx_valid_q <= 1'b0;
            cr_q       <= tx_data_q == 8'h0D;
            idx_q      <= idx_q + 1'b1;
            if (last_d) begin
              tmr_q   <= TMR_W'(ACK_TIMEOUT_CYC);
              win_q   <= '0;
              state_q <= S_WAIT;
            end else if (idx_q == IW'(CMD_WIDTH-1)) begin
              fail_q      <= 1'b1;
              busy_q      <= 1'b0;
              fail_code_q <= 3'd2;
              fail_cmd_q  <= k_q;
              state_q     <= S_FAIL;
            end else begin
              state_q <= S_FETCH;
            end
          end
          S_WAIT: begin
            if (win_ok_d) begin
              k_q     <= k_q + 1'b1;
              r_q     <= '0;
              base_q  <= base_q + ADDR_W'(CMD_WIDTH);
              tmr_q   <= TMR_W'(FLUSH_QUIET_CYC);
              state_q <= S_FLUSH;
            end else if (win_err_d || (!rx_valid_i && tmr_q == '0)) begin
              if (r_q < RW'(MAX_RETRIES)) begin
                r_q     <= r_q + 1'b1;
                tmr_q   <= TMR_W'(FLUSH_QUIET_CYC);
                state_q <= S_FLUSH;
              end else begin
                fail_q      <= 1'b1;
                busy_q      <= 1'b0;
                fail_code_q <= win_err_d ? 3'd4 : 3'd3;
                fail_cmd_q  <= k_q;
                state_q     <= S_FAIL;
              end
            end else if (rx_valid_i) begin
              win_q <= {win_q[31:0], rx_data_i};
              tmr_q <= TMR_W'(ACK_TIMEOUT_CYC);
            end else begin
              tmr_q <= tmr_q - 1'b1;
            end
          end
          S_FLUSH: begin
            if (rx_valid_i) begin
              tmr_q <= TMR_W'(FLUSH_QUIET_CYC);
            end else if (tmr_q == '0) begin
              idx_q   <= '0;
              cr_q    <= 1'b0;
              done_q  <= k_q == n_q;
              busy_q  <= k_q != n_q;
              state_q <= (k_q == n_q) ? S_DONE : S_FETCH;
            end else begin
              tmr_q <= tmr_q - 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_at_cmd_sequencer.sv
// tb_at_cmd_sequencer: directed self-checking bench for at_cmd_sequencer
module tb_at_cmd_sequencer;
  logic       clk = 0, rst = 1, start = 0, abort = 0, tx_ready = 1;
  logic       mem_rd_en, mem_rd_valid = 0, tx_valid, rx_valid, rx_rd_en;
  logic       busy, done, fail;
  logic [9:0] mem_addr;
  logic [7:0] mem_rd_data = 0, tx_data, rx_data;
  logic [2:0] fail_code;
  logic [4:0] fail_cmd, cmds_ok;
  logic [7:0] mem [0:1023];
  logic [7:0] rx_buf [0:255];
  logic [7:0] tx_log [0:1023];
  logic [7:0] rx_head = 0, rx_tail = 0, hold_d = 0;
  logic       hold_q = 0;
  logic [7:0] ok_s [6] = '{8'h0D, 8'h0A, 8'h4F, 8'h4B, 8'h0D, 8'h0A};
  logic [7:0] err_s [5] = '{8'h45, 8'h52, 8'h52, 8'h4F, 8'h52};
  int tx_n = 0, pops = 0, cyc = 0, last_lf = 0, stab_err = 0, resp_mode = 0;
  int n_chk = 0, n_fail = 0;
  int b, p, c, lat;

  at_cmd_sequencer #(
    .CMD_WIDTH(32), .MAX_CMDS(16), .ADDR_W(10), .MAX_RETRIES(1),
    .ACK_TIMEOUT_CYC(100), .FLUSH_QUIET_CYC(8), .TMR_W(24)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start), .abort_i(abort),
    .mem_rd_en_o(mem_rd_en), .mem_addr_o(mem_addr), .mem_rd_data_i(mem_rd_data),
    .mem_rd_valid_i(mem_rd_valid), .tx_valid_o(tx_valid), .tx_data_o(tx_data),
    .tx_ready_i(tx_ready), .rx_valid_i(rx_valid), .rx_data_i(rx_data), .rx_rd_en_o(rx_rd_en),
    .busy_o(busy), .done_o(done), .fail_o(fail), .fail_code_o(fail_code),
    .fail_cmd_o(fail_cmd), .cmds_ok_o(cmds_ok)
  );

  always #5 clk = ~clk;

  assign rx_valid = rx_head != rx_tail;
  assign rx_data  = rx_buf[rx_head];

  // Memory, RX FIFO and TX sink models; a reply is queued whenever a line feed is sent
  always @(posedge clk) begin
    cyc          <= cyc + 1;
    mem_rd_valid <= mem_rd_en;
    mem_rd_data  <= mem[mem_addr];
    hold_q       <= tx_valid && !tx_ready;
    hold_d       <= tx_data;
    if (hold_q && (!tx_valid || tx_data != hold_d)) stab_err <= stab_err + 1;
    if (rx_rd_en) begin
      rx_head <= rx_head + 8'd1;
      pops    <= pops + 1;
    end
    if (tx_valid && tx_ready) begin
      tx_log[tx_n[9:0]] <= tx_data;
      tx_n <= tx_n + 1;
      if (tx_data == 8'h0A) begin
        last_lf <= cyc;
        if (resp_mode == 1) begin
          for (int i = 0; i < 6; i++) rx_buf[rx_tail + 8'(i)] <= ok_s[i];
          rx_tail <= rx_tail + 8'd6;
        end else if (resp_mode == 2) begin
          for (int i = 0; i < 5; i++) rx_buf[rx_tail + 8'(i)] <= err_s[i];
          rx_tail <= rx_tail + 8'd5;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_cmd(input int k, input string s);
    for (int i = 0; i < s.len(); i++) mem[1 + k*32 + i] = s[i];
    mem[1 + k*32 + s.len()]     = 8'h0D;
    mem[1 + k*32 + s.len() + 1] = 8'h0A;
  endtask

  task automatic pulse_start;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
  endtask

  task automatic wait_end(input string tag, input int maxc);
    int k = 0;
    while (!(done || fail) && k < maxc) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_finished"}, 32'(done | fail), 1);
  endtask

  task automatic check_tx(input string tag, input int base, input string exp);
    int bad = 0;
    check({tag, "_tx_cnt"}, tx_n - base, exp.len());
    for (int i = 0; i < exp.len(); i++) if (tx_log[base + i] !== exp[i]) bad++;
    check({tag, "_tx_seq_errs"}, bad, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fail", fail, 0);
    check("rst_code", fail_code, 0);
    check("rst_cmds_ok", cmds_ok, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_mem_rd_en", mem_rd_en, 0);
    rst = 0;
    // two commands, both acknowledged with "\r\nOK\r\n"
    mem[0] = 8'd2; set_cmd(0, "AT"); set_cmd(1, "AT+NAMEX"); resp_mode = 1;
    b = tx_n; p = pops;
    pulse_start;
    check("t1_busy", busy, 1);
    wait_end("t1", 3000);
    check("t1_done", done, 1);
    check("t1_fail", fail, 0);
    check("t1_cmds_ok", cmds_ok, 2);
    check("t1_pops", pops - p, 12);
    check_tx("t1", b, "AT\r\nAT+NAMEX\r\n");
    repeat (5) @(negedge clk);
    check("t1_done_held", done, 1);
    check("t1_busy_end", busy, 0);
    // back-pressure for 20 cycles after the third byte
    mem[0] = 8'd1; set_cmd(0, "AT+NAMEX");
    b = tx_n;
    pulse_start;
    check("t2_done_cleared", done, 0);
    c = 0;
    while (tx_n - b < 3 && c < 500) begin @(negedge clk); c++; end
    tx_ready = 0;
    repeat (20) @(negedge clk);
    check("t2_no_xfer_in_hold", tx_n - b, 3);
    check("t2_valid_held", tx_valid, 1);
    check("t2_data_held", tx_data, 8'h4E);
    tx_ready = 1;
    wait_end("t2", 3000);
    check("t2_done", done, 1);
    check("t2_cmds_ok", cmds_ok, 1);
    check("t2_stable", stab_err, 0);
    check_tx("t2", b, "AT+NAMEX\r\n");
    // ERROR on both attempts
    set_cmd(0, "AT"); resp_mode = 2;
    b = tx_n;
    pulse_start;
    wait_end("t3", 3000);
    check("t3_fail", fail, 1);
    check("t3_code", fail_code, 4);
    check("t3_cmd", fail_cmd, 0);
    check("t3_done", done, 0);
    check("t3_cmds_ok", cmds_ok, 0);
    check_tx("t3", b, "AT\r\nAT\r\n");
    // no reply: timeout after the retry
    resp_mode = 0;
    b = tx_n; p = pops;
    pulse_start;
    wait_end("t4", 3000);
    lat = cyc - last_lf - 1;
    check("t4_code", fail_code, 3);
    check("t4_latency_98_to_102", 32'(lat >= 98 && lat <= 102), 1);
    check("t4_pops", pops - p, 0);
    check_tx("t4", b, "AT\r\nAT\r\n");
    // illegal command counts
    mem[0] = 8'd0;
    b = tx_n; p = pops;
    pulse_start;
    wait_end("t5a", 100);
    check("t5a_code", fail_code, 1);
    check("t5a_tx", tx_n - b, 0);
    mem[0] = 8'd17;
    pulse_start;
    wait_end("t5b", 100);
    check("t5b_code", fail_code, 1);
    check("t5b_pops", pops - p, 0);
    // full slot with no terminator
    mem[0] = 8'd1;
    for (int i = 0; i < 32; i++) mem[1 + i] = 8'h41;
    mem[33] = 8'h0D; mem[34] = 8'h0A;
    b = tx_n; p = pops;
    pulse_start;
    wait_end("t6", 1000);
    check("t6_code", fail_code, 2);
    check("t6_tx", tx_n - b, 32);
    check("t6_pops", pops - p, 0);
    // abort while waiting for the reply, then a clean rerun
    set_cmd(0, "AT");
    b = tx_n;
    pulse_start;
    c = 0;
    while (tx_n - b < 4 && c < 500) begin @(negedge clk); c++; end
    repeat (10) @(negedge clk);
    check("t7_busy_wait", busy, 1);
    abort = 1;
    @(negedge clk); abort = 0;
    check("t7_fail", fail, 1);
    check("t7_code", fail_code, 5);
    check("t7_busy", busy, 0);
    check("t7_tx_valid", tx_valid, 0);
    check("t7_rx_rd_en", rx_rd_en, 0);
    repeat (3) @(negedge clk);
    check("t7_fail_held", fail, 1);
    resp_mode = 1;
    pulse_start;
    check("t7_fail_cleared", fail, 0);
    check("t7_code_cleared", fail_code, 0);
    wait_end("t7", 3000);
    check("t7_done", done, 1);
    check("t7_cmds_ok", cmds_ok, 1);
    check("t7_fail_end", fail, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
